alu: RTL and testbench



---
 rtl/alu.sv | 107 ++++++++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit registered ALU: logic, add/sub, shift, rotate, compare and pass ops
// with one output register stage. ALU_SAT_EN selects saturating ADD/SUB.
module alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       ctrl,
  input  logic             Flag,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int unsigned SHW   = 3;
  localparam int unsigned WIDE  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDE-1:0]  shl_wide;
  logic [WIDE-1:0]  rot_wide;
  logic [WIDE-1:0]  ror_wide;
  logic [WIDE-1:0]  rol_wide;
  logic [WIDTH-1:0] arith_res;
  logic             arith_ovf;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  assign amt      = rs2[SHW-1:0];
  assign sum      = rs1 + rs2;
  assign diff     = rs1 - rs2;
  assign add_ovf  = (rs1[WIDTH-1] == rs2[WIDTH-1]) && (sum[WIDTH-1] != rs1[WIDTH-1]);
  assign sub_ovf  = (rs1[WIDTH-1] != rs2[WIDTH-1]) && (diff[WIDTH-1] != rs1[WIDTH-1]);

  // Upper half of the widened left shift holds the bits pushed out.
  assign shl_wide = {{WIDTH{1'b0}}, rs1} << amt;
  assign rot_wide = {rs1, rs1};
  assign ror_wide = rot_wide >> amt;
  assign rol_wide = rot_wide << amt;

  // Signed overflow direction always follows the sign of rs1 for both ADD and SUB.
  always_comb begin
    arith_res = Flag ? diff : sum;
    arith_ovf = Flag ? sub_ovf : add_ovf;
`ifdef ALU_SAT_EN
    if (arith_ovf) begin
      arith_res = rs1[WIDTH-1] ? SMIN : SMAX;
    end
`endif
  end

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (ctrl)
      3'b000: res_c = Flag ? ~(rs1 & rs2) : ~(rs1 | rs2);
      3'b001,
      3'b011: begin
        res_c = arith_res;
        ovf_c = arith_ovf;
      end
      3'b010: res_c = Flag ? ~(rs1 ^ rs2) : (rs1 ^ rs2);
      3'b100: begin
        if (Flag) begin
          res_c = shl_wide[WIDTH-1:0];
          ovf_c = |shl_wide[WIDE-1:WIDTH];
        end else begin
          res_c = rs1 >> amt;
        end
      end
      3'b101: res_c = Flag ? rol_wide[WIDE-1:WIDTH] : ror_wide[WIDTH-1:0];
      3'b110: begin
        if (Flag) begin
          res_c = WIDTH'(rs1 < rs2);
        end else begin
          res_c = WIDTH'($signed(rs1) < $signed(rs2));
        end
      end
      3'b111: res_c = Flag ? rs2 : rs1;
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      out      <= res_c;
      overflow <= ovf_c;
    end
  end

  // Saturation constants are only referenced when ALU_SAT_EN is defined.
  logic unused_sat;
  assign unused_sat = ^{SMAX, SMIN};

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset corner sequence and
// randomized ops against an integer-arithmetic reference model.
module tb_alu;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [2:0]       ctrl;
  logic             Flag;
  logic [WIDTH-1:0] out;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .ctrl(ctrl), .Flag(Flag), .out(out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] c;
    logic       f;
    logic [7:0] eo;
    logic       ev;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got_o, input logic got_v,
                       input logic [7:0] exp_o, input logic exp_v);
    checks++;
    if (got_o !== exp_o || got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got out=%h ovf=%b, required out=%h ovf=%b",
               name, got_o, got_v, exp_o, exp_v);
    end
  endtask

  // Reference model from the op table using plain integer arithmetic.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                       input logic f, output logic [7:0] o, output logic v);
    int ua, ub, sa, sb, n, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    n  = ub % 8;
    r  = 0;
    v  = 1'b0;
    case (c)
      3'd0: r = f ? (255 - (ua & ub)) : (255 - (ua | ub));
      3'd1, 3'd3: begin
        r = f ? (sa - sb) : (sa + sb);
        v = (r > 127) || (r < -128);
`ifdef ALU_SAT_EN
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`endif
      end
      3'd2: r = f ? (255 - (ua ^ ub)) : (ua ^ ub);
      3'd4: begin
        if (f) begin
          r = ua * (1 << n);
          v = (r >= 256);
        end else begin
          r = ua / (1 << n);
        end
      end
      3'd5: r = f ? ((ua * (1 << n)) + (ua / (1 << (8 - n))))
                  : ((ua / (1 << n)) + (ua * (1 << (8 - n))));
      3'd6: r = f ? ((ua < ub) ? 1 : 0) : ((sa < sb) ? 1 : 0);
      default: r = f ? ub : ua;
    endcase
    o = 8'(r & 255);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                       input logic f);
    rs1  = a;
    rs2  = b;
    ctrl = c;
    Flag = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] eo;
    logic       ev;

    vecs.push_back('{"nand",      8'h05, 8'h01, 3'b000, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{"nor",       8'h05, 8'h01, 3'b000, 1'b0, 8'hFA, 1'b0});
    vecs.push_back('{"add_011",   8'h05, 8'h01, 3'b011, 1'b0, 8'h06, 1'b0});
    vecs.push_back('{"sub_001",   8'h05, 8'h01, 3'b001, 1'b1, 8'h04, 1'b0});
    vecs.push_back('{"srl",       8'h05, 8'h01, 3'b100, 1'b0, 8'h02, 1'b0});
    vecs.push_back('{"sll",       8'h05, 8'h01, 3'b100, 1'b1, 8'h0A, 1'b0});
`ifdef ALU_SAT_EN
    vecs.push_back('{"add_povf",  8'h7F, 8'h01, 3'b001, 1'b0, 8'h7F, 1'b1});
    vecs.push_back('{"sub_novf",  8'h80, 8'h01, 3'b001, 1'b1, 8'h80, 1'b1});
    vecs.push_back('{"add_novf",  8'h80, 8'hFF, 3'b011, 1'b0, 8'h80, 1'b1});
    vecs.push_back('{"sub_povf",  8'h7F, 8'hFF, 3'b011, 1'b1, 8'h7F, 1'b1});
`else
    vecs.push_back('{"add_povf",  8'h7F, 8'h01, 3'b001, 1'b0, 8'h80, 1'b1});
    vecs.push_back('{"sub_novf",  8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 1'b1});
    vecs.push_back('{"add_novf",  8'h80, 8'hFF, 3'b011, 1'b0, 8'h7F, 1'b1});
    vecs.push_back('{"sub_povf",  8'h7F, 8'hFF, 3'b011, 1'b1, 8'h80, 1'b1});
`endif
    vecs.push_back('{"sll_out",   8'h81, 8'h01, 3'b100, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{"slt_s",     8'hFF, 8'h01, 3'b110, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{"slt_u",     8'hFF, 8'h01, 3'b110, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{"sll_amt0",  8'h5A, 8'h08, 3'b100, 1'b1, 8'h5A, 1'b0});
    vecs.push_back('{"srl_amt0",  8'hA5, 8'hF8, 3'b100, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{"ror",       8'h81, 8'h01, 3'b101, 1'b0, 8'hC0, 1'b0});
    vecs.push_back('{"rol",       8'h81, 8'h01, 3'b101, 1'b1, 8'h03, 1'b0});
    vecs.push_back('{"rol7",      8'h01, 8'h07, 3'b101, 1'b1, 8'h80, 1'b0});
    vecs.push_back('{"xor",       8'h0F, 8'hFF, 3'b010, 1'b0, 8'hF0, 1'b0});
    vecs.push_back('{"xnor",      8'h0F, 8'hFF, 3'b010, 1'b1, 8'h0F, 1'b0});
    vecs.push_back('{"pass_a",    8'h12, 8'h34, 3'b111, 1'b0, 8'h12, 1'b0});
    vecs.push_back('{"pass_b",    8'h12, 8'h34, 3'b111, 1'b1, 8'h34, 1'b0});

    rst  = 1'b1;
    rs1  = '0;
    rs2  = '0;
    ctrl = '0;
    Flag = 1'b0;
    #3;
    check("reset_state", out, overflow, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].f);
      check(vecs[i].name, out, overflow, vecs[i].eo, vecs[i].ev);
    end

    // Async reset mid-stream with a nonzero, overflowing result held.
    drive(8'h81, 8'h01, 3'b100, 1'b1);
    check("pre_rst", out, overflow, 8'h02, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", out, overflow, 8'h00, 1'b0);
    drive(8'hA5, 8'h00, 3'b111, 1'b0);
    check("rst_held", out, overflow, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_release_no_edge", out, overflow, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_fresh", out, overflow, 8'hA5, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      logic [2:0] c;
      logic       f;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 3'($urandom);
      f = 1'($urandom);
      model(a, b, c, f, eo, ev);
      drive(a, b, c, f);
      check($sformatf("rand%0d_a%h_b%h_c%0d_f%0d", i, a, b, c, f), out, overflow, eo, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
